alu_rs_scheduler: RTL and testbench

- Reservation station and issue scheduler for the shared integer ALU in the out-of-order core.
- Takes decoded ALU/branch/jump/U-type ops from the dispatcher and holds them until both operands are valid.
- Snoops the ALU and load/store common-data broadcasts to resolve operand tags.
- Each cycle it launches at most one ready op into the ALU with a registered new_calculate pulse; it sits between the decoder/ROB allocator and the ALU.

---
 rtl/alu_rs_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds ops until both operands are valid,
// snoops CDB broadcasts, launches the lowest ready entry each cycle.
module alu_rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [31:0]      issue_instruction,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [TAG_W-1:0] issue_entry,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  output logic             rs_full,
  input  logic             alu_broadcast,
  input  logic [31:0]      alu_result,
  input  logic [TAG_W-1:0] alu_entry,
  input  logic             lsb_broadcast,
  input  logic [31:0]      lsb_result,
  input  logic [TAG_W-1:0] lsb_entry,
  output logic             new_calculate,
  output logic [31:0]      ex_instruction,
  output logic [5:0]       ex_op,
  output logic [31:0]      ex_vj,
  output logic [31:0]      ex_vk,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_imm,
  output logic [TAG_W-1:0] ex_entry
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;
  logic [5:0]         r_op  [RS_SIZE];
  logic [31:0]        r_ins [RS_SIZE];
  logic [31:0]        r_pc  [RS_SIZE];
  logic [31:0]        r_imm [RS_SIZE];
  logic [31:0]        r_vj  [RS_SIZE];
  logic [31:0]        r_vk  [RS_SIZE];
  logic [TAG_W-1:0]   r_ent [RS_SIZE];
  logic [TAG_W-1:0]   r_qj  [RS_SIZE];
  logic [TAG_W-1:0]   r_qk  [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic [IW-1:0]      w_free_idx;
  logic [IW-1:0]      w_sel_idx;
  logic               w_free_ok;
  logic               w_sel_ok;
  logic [31:0]        w_iss_vj;
  logic [31:0]        w_iss_vk;
  logic               w_iss_qjb;
  logic               w_iss_qkb;

  assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign rs_full = &r_busy;

  // Priority encoders: lowest free slot and lowest ready slot.
  always_comb begin
    w_free_idx = '0;
    w_free_ok  = 1'b0;
    w_sel_idx  = '0;
    w_sel_ok   = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IW'(i);
        w_free_ok  = 1'b1;
      end
      if (w_ready[i]) begin
        w_sel_idx = IW'(i);
        w_sel_ok  = 1'b1;
      end
    end
  end

  // Same-cycle bypass of a broadcast into the op being issued.
  always_comb begin
    w_iss_vj  = issue_vj;
    w_iss_qjb = issue_qj_busy;
    w_iss_vk  = issue_vk;
    w_iss_qkb = issue_qk_busy;
    if (issue_qj_busy && alu_broadcast && alu_entry == issue_qj) begin
      w_iss_vj  = alu_result;
      w_iss_qjb = 1'b0;
    end else if (issue_qj_busy && lsb_broadcast && lsb_entry == issue_qj) begin
      w_iss_vj  = lsb_result;
      w_iss_qjb = 1'b0;
    end
    if (issue_qk_busy && alu_broadcast && alu_entry == issue_qk) begin
      w_iss_vk  = alu_result;
      w_iss_qkb = 1'b0;
    end else if (issue_qk_busy && lsb_broadcast && lsb_entry == issue_qk) begin
      w_iss_vk  = lsb_result;
      w_iss_qkb = 1'b0;
    end
  end

  // Station state, wakeup, issue write and launch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy         <= '0;
      r_qj_busy      <= '0;
      r_qk_busy      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_ins[i] <= '0;
        r_pc[i]  <= '0;
        r_imm[i] <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_ent[i] <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
      end
      new_calculate  <= 1'b0;
      ex_instruction <= '0;
      ex_op          <= '0;
      ex_vj          <= '0;
      ex_vk          <= '0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_entry       <= '0;
    end else if (!rdy) begin
      new_calculate <= 1'b0;
    end else if (clear) begin
      r_busy        <= '0;
      new_calculate <= 1'b0;
    end else begin
      new_calculate <= w_sel_ok;
      if (w_sel_ok) begin
        ex_instruction    <= r_ins[w_sel_idx];
        ex_op             <= r_op[w_sel_idx];
        ex_vj             <= r_vj[w_sel_idx];
        ex_vk             <= r_vk[w_sel_idx];
        ex_pc             <= r_pc[w_sel_idx];
        ex_imm            <= r_imm[w_sel_idx];
        ex_entry          <= r_ent[w_sel_idx];
        r_busy[w_sel_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_busy[i]) begin
          if (alu_broadcast && alu_entry == r_qj[i]) begin
            r_vj[i]      <= alu_result;
            r_qj_busy[i] <= 1'b0;
          end else if (lsb_broadcast && lsb_entry == r_qj[i]) begin
            r_vj[i]      <= lsb_result;
            r_qj_busy[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_busy[i]) begin
          if (alu_broadcast && alu_entry == r_qk[i]) begin
            r_vk[i]      <= alu_result;
            r_qk_busy[i] <= 1'b0;
          end else if (lsb_broadcast && lsb_entry == r_qk[i]) begin
            r_vk[i]      <= lsb_result;
            r_qk_busy[i] <= 1'b0;
          end
        end
      end
      if (issue_valid && w_free_ok) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= issue_op;
        r_ins[w_free_idx]     <= issue_instruction;
        r_pc[w_free_idx]      <= issue_pc;
        r_imm[w_free_idx]     <= issue_imm;
        r_ent[w_free_idx]     <= issue_entry;
        r_vj[w_free_idx]      <= w_iss_vj;
        r_vk[w_free_idx]      <= w_iss_vk;
        r_qj_busy[w_free_idx] <= w_iss_qjb;
        r_qk_busy[w_free_idx] <= w_iss_qkb;
        r_qj[w_free_idx]      <= issue_qj;
        r_qk[w_free_idx]      <= issue_qk;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Randomized + directed bench for alu_rs_scheduler against
// a behavioural station model.
module tb_alu_rs_scheduler;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy, clear, issue_valid;
  logic [31:0] issue_instruction, issue_pc, issue_imm;
  logic [5:0]  issue_op;
  logic [3:0]  issue_entry, issue_qj, issue_qk;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  logic        rs_full;
  logic        alu_broadcast, lsb_broadcast;
  logic [31:0] alu_result, lsb_result;
  logic [3:0]  alu_entry, lsb_entry;
  logic        new_calculate;
  logic [31:0] ex_instruction, ex_vj, ex_vk, ex_pc, ex_imm;
  logic [5:0]  ex_op;
  logic [3:0]  ex_entry;

  alu_rs_scheduler #(.RS_SIZE(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_instruction(issue_instruction),
    .issue_op(issue_op), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_entry(issue_entry), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result),
    .alu_entry(alu_entry), .lsb_broadcast(lsb_broadcast),
    .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .ex_instruction(ex_instruction),
    .ex_op(ex_op), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_entry(ex_entry)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] ins, pc, imm, vj, vk;
    logic [3:0]  ent, qj, qk;
    bit          qjb, qkb;
  } ent_t;

  ent_t        m [N];
  bit          e_nc, e_full;
  logic [5:0]  e_op;
  logic [31:0] e_ins, e_pc, e_imm, e_vj, e_vk;
  logic [3:0]  e_ent;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value an operand takes after snooping the broadcasts: {still_pending, value}.
  function automatic logic [32:0] resolve(bit qb, logic [3:0] q,
                                          logic [31:0] v);
    if (!qb) return {1'b0, v};
    if (alu_broadcast && alu_entry == q) return {1'b0, alu_result};
    if (lsb_broadcast && lsb_entry == q) return {1'b0, lsb_result};
    return {1'b1, v};
  endfunction

  function automatic bit all_busy();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i].busy = 1'b0;
    e_nc = 1'b0;
    e_full = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the pre-edge inputs.
  task automatic model_step();
    int sel, fr;
    logic [32:0] r;
    if (!rdy) begin
      e_nc = 1'b0;
      return;
    end
    if (clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      e_nc = 1'b0;
      e_full = 1'b0;
      return;
    end
    sel = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    e_nc = (sel >= 0);
    if (sel >= 0) begin
      e_op = m[sel].op;   e_ins = m[sel].ins; e_pc = m[sel].pc;
      e_imm = m[sel].imm; e_vj = m[sel].vj;   e_vk = m[sel].vk;
      e_ent = m[sel].ent;
      m[sel].busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        r = resolve(m[i].qjb, m[i].qj, m[i].vj);
        m[i].qjb = r[32]; m[i].vj = r[31:0];
        r = resolve(m[i].qkb, m[i].qk, m[i].vk);
        m[i].qkb = r[32]; m[i].vk = r[31:0];
      end
    end
    if (issue_valid && fr >= 0) begin
      m[fr].busy = 1'b1;
      m[fr].op = issue_op;   m[fr].ins = issue_instruction;
      m[fr].pc = issue_pc;   m[fr].imm = issue_imm;
      m[fr].ent = issue_entry;
      m[fr].qj = issue_qj;   m[fr].qk = issue_qk;
      r = resolve(issue_qj_busy, issue_qj, issue_vj);
      m[fr].qjb = r[32]; m[fr].vj = r[31:0];
      r = resolve(issue_qk_busy, issue_qk, issue_vk);
      m[fr].qkb = r[32]; m[fr].vk = r[31:0];
    end
    e_full = all_busy();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("new_calculate", 32'(new_calculate), 32'(e_nc));
    check("rs_full", 32'(rs_full), 32'(e_full));
    if (e_nc) begin
      check("ex_op", 32'(ex_op), 32'(e_op));
      check("ex_instruction", ex_instruction, e_ins);
      check("ex_pc", ex_pc, e_pc);
      check("ex_imm", ex_imm, e_imm);
      check("ex_vj", ex_vj, e_vj);
      check("ex_vk", ex_vk, e_vk);
      check("ex_entry", 32'(ex_entry), 32'(e_ent));
    end
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    alu_broadcast = 1'b0; lsb_broadcast = 1'b0;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] vj,
                     input logic [31:0] vk, input bit qjb,
                     input logic [3:0] qj, input bit qkb,
                     input logic [3:0] qk, input logic [3:0] ent,
                     input logic [31:0] imm);
    issue_valid = 1'b1;
    issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = qjb; issue_qj = qj;
    issue_qk_busy = qkb; issue_qk = qk;
    issue_entry = ent; issue_imm = imm;
    issue_pc = $urandom; issue_instruction = $urandom;
  endtask

  task automatic bcast_alu(input logic [3:0] t, input logic [31:0] v);
    alu_broadcast = 1'b1; alu_entry = t; alu_result = v;
  endtask

  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_ADD  = 6'd1;

  initial begin
    idle();
    issue_instruction = '0; issue_op = '0; issue_pc = '0; issue_imm = '0;
    issue_entry = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_busy = 1'b0; issue_qk_busy = 1'b0; issue_qj = '0; issue_qk = '0;
    alu_result = '0; alu_entry = '0; lsb_result = '0; lsb_entry = '0;
    model_reset();
    #12;
    check("reset_nc", 32'(new_calculate), 32'd0);
    check("reset_full", 32'(rs_full), 32'd0);
    check("reset_ex_vj", ex_vj, 32'd0);
    check("reset_ex_op", 32'(ex_op), 32'd0);
    check("reset_ex_entry", 32'(ex_entry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready op launches one cycle after issue.
    put(OP_ADDI, 32'd5, 32'd0, 0, 4'd0, 0, 4'd0, 4'd2, 32'd3);
    tick();
    idle();
    tick();
    check("t1_vj", ex_vj, 32'd5);
    check("t1_imm", ex_imm, 32'd3);
    check("t1_entry", 32'(ex_entry), 32'd2);
    check("t1_op", 32'(ex_op), 32'(OP_ADDI));
    tick();

    // Wakeup by ALU broadcast.
    put(OP_ADD, 32'd0, 32'd10, 1, 4'd7, 0, 4'd0, 4'd1, 32'd0);
    tick();
    idle();
    repeat (3) tick();
    bcast_alu(4'd7, 32'h20);
    tick();
    idle();
    tick();
    check("t2_nc", 32'(new_calculate), 32'd1);
    check("t2_vj", ex_vj, 32'h20);
    check("t2_vk", ex_vk, 32'd10);
    tick();

    // Issue-cycle bypass from the load broadcast.
    put(OP_ADD, 32'd1, 32'd0, 0, 4'd0, 1, 4'd4, 4'd3, 32'd0);
    lsb_broadcast = 1'b1; lsb_entry = 4'd4; lsb_result = 32'hDEAD;
    tick();
    idle();
    tick();
    check("t3_vk", ex_vk, 32'hDEAD);
    tick();

    // Fill the station, free slot 9, refill it.
    for (int i = 0; i < N; i++) begin
      put(OP_ADD, 32'(i), 32'd0, 1, (i == 9) ? 4'd9 : 4'd5, 0, 4'd0,
          4'(i), 32'(i));
      tick();
    end
    idle();
    check("t4_full", 32'(rs_full), 32'd1);
    bcast_alu(4'd9, 32'h99);
    tick();
    idle();
    tick();
    check("t4_launch9", 32'(ex_entry), 32'd9);
    check("t4_notfull", 32'(rs_full), 32'd0);
    put(OP_ADD, 32'd0, 32'd0, 1, 4'd5, 0, 4'd0, 4'd14, 32'd0);
    tick();
    idle();
    check("t4_refull", 32'(rs_full), 32'd1);
    bcast_alu(4'd5, 32'h55);
    tick();
    idle();
    for (int k = 0; k < N; k++) begin
      tick();
      if (k == 9) check("t4_slot9", 32'(ex_entry), 32'd14);
    end
    tick();

    // Two entries ready on the same edge, with a stall between launches.
    for (int i = 0; i < 6; i++) begin
      put(OP_ADD, 32'(i), 32'd0, 1, (i == 3 || i == 5) ? 4'd1 : 4'd2,
          0, 4'd0, 4'(i), 32'd0);
      tick();
    end
    idle();
    bcast_alu(4'd1, 32'h11);
    tick();
    idle();
    tick();
    check("t5_first", 32'(ex_entry), 32'd3);
    rdy = 1'b0;
    tick();
    check("t5_stall", 32'(new_calculate), 32'd0);
    rdy = 1'b1;
    tick();
    check("t5_second", 32'(ex_entry), 32'd5);

    // Clear with six busy entries and a simultaneous issue.
    for (int i = 0; i < 2; i++) begin
      put(OP_ADD, 32'd0, 32'd0, 1, 4'd2, 0, 4'd0, 4'd8, 32'd0);
      tick();
    end
    put(OP_ADDI, 32'd7, 32'd0, 0, 4'd0, 0, 4'd0, 4'd6, 32'd1);
    clear = 1'b1;
    tick();
    idle();
    check("t6_full", 32'(rs_full), 32'd0);
    check("t6_nc", 32'(new_calculate), 32'd0);
    bcast_alu(4'd2, 32'h22);
    tick();
    idle();
    repeat (3) tick();

    // Asynchronous reset while a launch is visible.
    put(OP_ADDI, 32'd9, 32'd0, 0, 4'd0, 0, 4'd0, 4'd4, 32'd2);
    tick();
    idle();
    tick();
    check("t6_pre_rst", 32'(new_calculate), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_nc", 32'(new_calculate), 32'd0);
    check("t6_rst_vj", ex_vj, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 63) == 0);
      if (!e_full && $urandom_range(0, 1) == 1)
        put(6'($urandom), $urandom, $urandom,
            $urandom_range(0, 2) == 0, 4'($urandom),
            $urandom_range(0, 2) == 0, 4'($urandom),
            4'($urandom), $urandom);
      if ($urandom_range(0, 9) < 4) bcast_alu(4'($urandom), $urandom);
      if ($urandom_range(0, 9) < 4) begin
        lsb_broadcast = 1'b1;
        lsb_entry = 4'($urandom);
        lsb_result = $urandom;
        if (alu_broadcast && lsb_entry == alu_entry)
          lsb_entry = alu_entry + 4'd1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
